bfly_stage_ctrl: RTL
====================

Name: bfly_stage_ctrl

Overview:
Sequencing controller for one 16-lane radix-2 butterfly stage of the 512-point FFT pipeline. It frames the incoming stream of 16-sample blocks (32 blocks per frame) and gates the butterfly's valid_in. It also carries block index and frame markers through a tag pipeline matched to the butterfly latency, so downstream twiddle/reorder logic receives aligned sof/eof/index. It detects framing and alignment errors.

Parameters:
BLK_PER_FRAME, 32, 16-sample blocks per FFT frame (power of two, >=2)
CNT_W, $clog2(BLK_PER_FRAME), width of block index
BF_LAT, 1, butterfly register latency in cycles (>=1)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
din_valid  input  1  upstream block valid (16 samples present this cycle)
din_sof  input  1  upstream block is first of a frame; qualified by din_valid
bf_valid_in  output  1  valid to butterfly; combinational
bf_valid_out  input  1  valid returned from butterfly
dout_valid  output  1  tagged output valid, aligned with butterfly outputs
dout_sof  output  1  first block of frame at butterfly output
dout_eof  output  1  last block of frame at butterfly output
dout_idx  output  CNT_W  block index of the current butterfly output
err_frame  output  1  one-cycle pulse on framing error
err_align  output  1  sticky; tag pipe and butterfly valid disagree
perf_frames  output  16  completed frames (feature-gated)
perf_drops  output  16  dropped blocks (feature-gated)

Behaviour:
- Reset (async, rstn low): FSM=IDLE, in_cnt=0, every tag-pipe stage cleared. Outputs dout_valid/sof/eof=0, dout_idx=0, err_frame=0, err_align=0, perf_*=0. Reset mid-frame abandons the frame and clears all in-flight tags; no eof is emitted for it.
- FSM states:
  - IDLE: din_valid&din_sof -> accept block, idx 0, go RUN (if BLK_PER_FRAME==1 it would end immediately; disallowed by the parameter rule). din_valid without sof -> drop block, err_frame pulse, stay IDLE.
  - RUN: each din_valid accepts one block with idx=in_cnt, then in_cnt++. din_valid low holds in_cnt; gaps are unlimited. Block with in_cnt==BLK_PER_FRAME-1 is tagged eof, in_cnt wraps to 0, go IDLE.
  - RUN with din_valid&din_sof while in_cnt!=0: resync. err_frame pulse, block accepted as idx 0 with sof, in_cnt=1. The truncated previous frame gets no eof.
  - Back-to-back frames: eof block and next sof block may be consecutive cycles with no bubble; the IDLE accept path handles the sof block on the very next cycle.
- bf_valid_in = din_valid & accept (accept=0 only for dropped blocks). Combinational, zero latency.
- Tag pipe: BF_LAT register stages of {valid, sof, eof, idx}; stage0 is loaded with the accepted block's tag each cycle (valid=0 otherwise). dout_* = last stage, so dout_valid rises exactly BF_LAT cycles after bf_valid_in.
- dout_sof/dout_eof/dout_idx are 0 whenever dout_valid=0.
- Alignment check: any cycle where dout_valid != bf_valid_out sets err_align; it clears only on reset.
- No backpressure: the controller never stalls upstream.

Optional Feature:
BFLY_CTRL_PERF_EN
- Defined: perf_frames increments on every dout_valid&dout_eof; perf_drops increments on every dropped block. Both saturate at 16'hFFFF.
- Undefined: both ports tied to 0, no counter flops synthesized.

Decomposition:
- Shared package fft_pkg:
  - FFT_N=512, LANES=16, BLK_PER_FRAME_DEF=32
  - typedef enum {IDLE, RUN} bfly_ctrl_state_t
  - typedef struct packed {valid, sof, eof, idx} bfly_tag_t
- Sub-module bfly_tag_pipe: parameterized BF_LAT-deep shift register of bfly_tag_t with async reset. This module instantiates it and owns the FSM, counters and checks.

Test Plan:
- Reset, then 32 consecutive valid blocks, first with sof -> bf_valid_in high 32 cycles; dout_valid high 32 cycles starting 1 cycle later; dout_sof on idx 0; dout_eof on idx 31; err_frame never pulses.
- Two frames back-to-back with no bubble -> dout_idx runs 0..31,0..31; eof immediately followed by sof; perf_frames=2 with BFLY_CTRL_PERF_EN.
- Frame with din_valid toggling every other cycle -> idx increments only on valid cycles; eof on the 32nd accepted block at cycle 63.
- 3 valid blocks without sof while IDLE -> bf_valid_in stays 0, three err_frame pulses, perf_drops=3.
- sof reasserted at in_cnt=10 -> err_frame pulse; that block output as idx 0 with sof; no eof for the truncated frame.
- Force bf_valid_out low for one cycle while dout_valid=1 -> err_align set and held. Assert rstn low mid-frame -> all outputs 0 asynchronously; a new sof after reset starts at idx 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the 512-point FFT pipeline.
// Butterfly stage sequencing tags and controller states.
package fft_pkg;

    localparam int FFT_N             = 512;
    localparam int LANES             = 16;
    localparam int BLK_PER_FRAME_DEF = FFT_N / LANES;

    // Wide enough for any frame length the pipeline will be built with
    localparam int TAG_IDX_W = 16;

    typedef enum logic {
        IDLE,
        RUN
    } bfly_ctrl_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 sof;
        logic                 eof;
        logic [TAG_IDX_W-1:0] idx;
    } bfly_tag_t;

    function automatic logic [15:0] sat_inc16(
        input logic [15:0] v
    );
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bfly_tag_pipe.sv
// BF_LAT-deep register pipe carrying block tags alongside
// the butterfly datapath.
module bfly_tag_pipe
    import fft_pkg::*;
#(
    parameter int BF_LAT = 1
) (
    input  logic      clk,
    input  logic      rstn,
    input  bfly_tag_t tag_in,
    output bfly_tag_t tag_out
);

    bfly_tag_t stg [BF_LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BF_LAT; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= tag_in;
            for (int i = 1; i < BF_LAT; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign tag_out = stg[BF_LAT-1];

endmodule

// File: rtl/bfly_stage_ctrl.sv
// Framing/tag controller for one radix-2 butterfly stage.
// Optional perf counters enabled by BFLY_CTRL_PERF_EN.
module bfly_stage_ctrl
    import fft_pkg::*;
#(
    parameter int BLK_PER_FRAME = BLK_PER_FRAME_DEF,
    parameter int CNT_W         = $clog2(BLK_PER_FRAME),
    parameter int BF_LAT        = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             din_valid,
    input  logic             din_sof,
    output logic             bf_valid_in,
    input  logic             bf_valid_out,
    output logic             dout_valid,
    output logic             dout_sof,
    output logic             dout_eof,
    output logic [CNT_W-1:0] dout_idx,
    output logic             err_frame,
    output logic             err_align,
    output logic [15:0]      perf_frames,
    output logic [15:0]      perf_drops
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_PER_FRAME - 1);

    bfly_ctrl_state_t state;
    logic [CNT_W-1:0] in_cnt;

    logic      accept;
    logic      drop;
    logic      resync;
    bfly_tag_t tag_in;
    bfly_tag_t tag_out;
    logic      unused_tag;

    // IDLE only takes a block that opens a frame
    assign accept = din_valid & ((state == RUN) | din_sof);
    assign drop   = din_valid & ~accept;
    assign resync = din_valid & din_sof
                  & (state == RUN) & (in_cnt != '0);

    assign bf_valid_in = accept;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = accept;
        tag_in.sof   = accept & din_sof;
        tag_in.eof   = accept & ~din_sof & (in_cnt == LAST);
        if (accept & ~din_sof) begin
            tag_in.idx = TAG_IDX_W'(in_cnt);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            in_cnt    <= '0;
            err_frame <= 1'b0;
            err_align <= 1'b0;
        end else begin
            err_frame <= drop | resync;
            if (dout_valid != bf_valid_out) begin
                err_align <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (din_valid & din_sof) begin
                        in_cnt <= CNT_W'(1);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (din_valid & din_sof) begin
                        in_cnt <= CNT_W'(1);
                    end else if (din_valid) begin
                        if (in_cnt == LAST) begin
                            in_cnt <= '0;
                            state  <= IDLE;
                        end else begin
                            in_cnt <= in_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    bfly_tag_pipe #(
        .BF_LAT (BF_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign dout_valid = tag_out.valid;
    assign dout_sof   = tag_out.valid & tag_out.sof;
    assign dout_eof   = tag_out.valid & tag_out.eof;
    assign dout_idx   = tag_out.valid ? tag_out.idx[CNT_W-1:0]
                                      : '0;
    assign unused_tag = ^tag_out.idx;

`ifdef BFLY_CTRL_PERF_EN
    logic [15:0] frames_q;
    logic [15:0] drops_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frames_q <= '0;
            drops_q  <= '0;
        end else begin
            if (dout_valid & dout_eof) begin
                frames_q <= sat_inc16(frames_q);
            end
            if (drop) begin
                drops_q <= sat_inc16(drops_q);
            end
        end
    end

    assign perf_frames = frames_q;
    assign perf_drops  = drops_q;
`else
    assign perf_frames = '0;
    assign perf_drops  = '0;
`endif

endmodule
